lv_wdg_win_ctrl: RTL



---
 rtl/lv_wdg_win_ctrl.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/lv_wdg_win_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lv_wdg_win_ctrl
// Purpose  : Windowed watchdog for the LV die. Times MCU refresh writes
//            arriving over SPI while the control FSM holds the scan enable.
//            Timeouts, early refreshes and bad keys raise a sticky error flag
//            that feeds the control FSM's watchdog-timeout error input.
// Ports    : i_clk / i_rst        clock, asynchronous active-high reset
//            i_wdg_scan_en        level enable from the control FSM
//            i_wdg_refresh        one-cycle refresh write pulse
//            i_wdg_key            refresh data, sampled with i_wdg_refresh
//            i_reg_wdg_presc      one tick every presc+1 clocks
//            i_reg_wdg_win_th     closed-window length in ticks
//            i_reg_wdg_tmo_th     timeout in ticks since last good refresh
//            i_reg_wdg_err_clr    one-cycle pulse clearing the error flag
//            o_wdg_tmo_err        sticky error flag
//            o_wdg_err_code       first error: 01 tmo, 10 early, 11 bad key
//            o_wdg_refresh_ok     one-cycle pulse per accepted refresh
//            o_wdg_cnt            current tick count
//            o_wdg_st             IDLE=0, CLOSED=1, OPEN=2, EXPIRED=3
// Revision : 1.0 - initial release
// ============================================================================
module lv_wdg_win_ctrl #(
    parameter int          CNT_W   = 16,
    parameter int          PRESC_W = 8,
    parameter logic [7:0]  WDG_KEY = 8'hA5
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_wdg_scan_en,
    input  logic               i_wdg_refresh,
    input  logic [7:0]         i_wdg_key,
    input  logic [PRESC_W-1:0] i_reg_wdg_presc,
    input  logic [CNT_W-1:0]   i_reg_wdg_win_th,
    input  logic [CNT_W-1:0]   i_reg_wdg_tmo_th,
    input  logic               i_reg_wdg_err_clr,
    output logic               o_wdg_tmo_err,
    output logic [1:0]         o_wdg_err_code,
    output logic               o_wdg_refresh_ok,
    output logic [CNT_W-1:0]   o_wdg_cnt,
    output logic [1:0]         o_wdg_st
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CLOSED  = 2'd1,
        ST_OPEN    = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    localparam logic [1:0] c_code_tmo   = 2'b01;
    localparam logic [1:0] c_code_early = 2'b10;
    localparam logic [1:0] c_code_key   = 2'b11;

    localparam logic [CNT_W-1:0]   c_cnt_one   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [PRESC_W-1:0] c_presc_one = {{(PRESC_W-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               err_q, err_d;
    logic [1:0]         code_q, code_d;
    logic               ok_q, ok_d;

    logic               w_tick;
    logic               w_key_ok;
    logic               w_tmo_hit;
    logic [CNT_W-1:0]   w_cnt_run;
    logic [PRESC_W-1:0] w_presc_run;
    logic               w_new_err;
    logic [1:0]         w_new_code;

    assign w_tick    = (presc_q == i_reg_wdg_presc);
    assign w_key_ok  = (i_wdg_key == WDG_KEY);
    assign w_tmo_hit = (cnt_q >= i_reg_wdg_tmo_th);

    // Counter/prescaler values for a cycle spent counting in CLOSED or OPEN.
    // The counter saturates instead of wrapping so a huge timeout cannot
    // alias back into the closed window.
    always_comb begin
        w_cnt_run   = cnt_q;
        w_presc_run = presc_q + c_presc_one;
        if (w_tick) begin
            w_presc_run = '0;
            if (cnt_q != {CNT_W{1'b1}}) begin
                w_cnt_run = cnt_q + c_cnt_one;
            end
        end
    end

    // Next-state logic. Conditions inside each state are in priority order.
    // Every transition into EXPIRED leaves the counter untouched so the value
    // that caused the error stays visible for readback.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        presc_d    = presc_q;
        ok_d       = 1'b0;
        w_new_err  = 1'b0;
        w_new_code = 2'b00;

        if (!i_wdg_scan_en) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            presc_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_CLOSED;
                    cnt_d   = '0;
                    presc_d = '0;
                end
                ST_CLOSED: begin
                    if (w_tmo_hit) begin
                        w_new_err  = 1'b1;
                        w_new_code = c_code_tmo;
                    end else if (i_wdg_refresh && !w_key_ok) begin
                        w_new_err  = 1'b1;
                        w_new_code = c_code_key;
                    end else if (i_wdg_refresh) begin
                        w_new_err  = 1'b1;
                        w_new_code = c_code_early;
                    end else begin
                        cnt_d   = w_cnt_run;
                        presc_d = w_presc_run;
                        if (cnt_q >= i_reg_wdg_win_th) begin
                            state_d = ST_OPEN;
                        end
                    end
                end
                ST_OPEN: begin
                    if (w_tmo_hit) begin
                        w_new_err  = 1'b1;
                        w_new_code = c_code_tmo;
                    end else if (i_wdg_refresh && !w_key_ok) begin
                        w_new_err  = 1'b1;
                        w_new_code = c_code_key;
                    end else if (i_wdg_refresh) begin
                        state_d = ST_CLOSED;
                        cnt_d   = '0;
                        presc_d = '0;
                        ok_d    = 1'b1;
                    end else begin
                        cnt_d   = w_cnt_run;
                        presc_d = w_presc_run;
                    end
                end
                ST_EXPIRED: begin
                    if (i_reg_wdg_err_clr) begin
                        state_d = ST_CLOSED;
                        cnt_d   = '0;
                        presc_d = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
            if (w_new_err) begin
                state_d = ST_EXPIRED;
            end
        end
    end

    // Error flag and code. Only the first error is recorded, but a clear in
    // the same cycle as a new error lets the new code through.
    always_comb begin
        err_d  = err_q;
        code_d = code_q;
        if (w_new_err) begin
            err_d = 1'b1;
            if (!err_q || i_reg_wdg_err_clr) begin
                code_d = w_new_code;
            end
        end else if (i_reg_wdg_err_clr) begin
            err_d  = 1'b0;
            code_d = 2'b00;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            presc_q <= '0;
            err_q   <= 1'b0;
            code_q  <= 2'b00;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            presc_q <= presc_d;
            err_q   <= err_d;
            code_q  <= code_d;
            ok_q    <= ok_d;
        end
    end

    assign o_wdg_tmo_err    = err_q;
    assign o_wdg_err_code   = code_q;
    assign o_wdg_refresh_ok = ok_q;
    assign o_wdg_cnt        = cnt_q;
    assign o_wdg_st         = state_q;

endmodule
`default_nettype wire
